// File: rtl/pipeline_stage_ctrl_pkg.sv
// rtl/pipeline_stage_ctrl_pkg.sv - shared state encoding for valid/ready stage controllers
package pipeline_stage_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] stage_state_t;

  localparam stage_state_t ST_EMPTY   = 2'b00;
  localparam stage_state_t ST_BUSY    = 2'b01;
  localparam stage_state_t ST_FULL    = 2'b10;
  localparam stage_state_t ST_ILLEGAL = 2'b11;

  // The illegal encoding reports zero held beats while it recovers.
  function automatic logic [1:0] state_occupancy(input stage_state_t s);
    case (s)
      ST_BUSY: state_occupancy = 2'd1;
      ST_FULL: state_occupancy = 2'd2;
      default: state_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_stage_ctrl_stage_data_reg.sv
// rtl/pipeline_stage_ctrl_stage_data_reg.sv - payload register with load enable and synchronous clear
module stage_data_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] data_q;

  // Clear wins over load so a squash drops a beat arriving in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// rtl/pipeline_stage_ctrl.sv - valid/ready stage controller with 2-entry skid buffer and stall counter
module pipeline_stage_ctrl
  import pipeline_stage_ctrl_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  input  logic          flush,
  input  logic          clear_stats,
  output logic [1:0]    occupancy,
  output logic [CW-1:0] stall_count
);

  stage_state_t  state_q, state_d;
  logic [CW-1:0] stall_q, stall_d;
  logic [N-1:0]  main_q, skid_q, main_d;
  logic          main_ld, skid_ld, main_from_skid;
  logic          acc, pop;

  // Outputs depend on registered state only.
  assign out_valid   = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign in_ready    = (state_q == ST_EMPTY) || (state_q == ST_BUSY);
  assign occupancy   = state_occupancy(state_q);
  assign out_data    = main_q;
  assign stall_count = stall_q;

  assign acc = in_valid & in_ready;
  assign pop = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d = ST_BUSY;
            main_ld = 1'b1;
          end
        end
        ST_BUSY: begin
          if (acc && pop) begin
            main_ld = 1'b1;
          end else if (acc) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d        = ST_BUSY;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  // Saturating stall statistic; flush leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (clear_stats) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && (stall_q != {CW{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  stage_data_reg #(.N(N)) u_main_reg (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (flush),
    .load_i (main_ld),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  stage_data_reg #(.N(N)) u_skid_reg (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (flush),
    .load_i (skid_ld),
    .d_i    (in_data),
    .q_o    (skid_q)
  );

endmodule
